// File: rtl/sseg_share_arbiter.sv
`timescale 1ns/1ps
// Purpose: time-shares one 8-digit seven-segment display between two requesters.
//          Configuration macro SSEG_ARB_BLANK_EN: defined -> owner changes pass through a BLANK gap.
// Latency: grant follows req after 1 edge; disp_out follows the owner's frame after 1 edge.
// Backpressure: req is a level; a waiting requester is held off until the owner releases or its slice expires.
module sseg_share_arbiter #(
    parameter int unsigned SLICE        = 100000000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [47:0] frame0,
    input  logic [47:0] frame1,
    output logic [1:0]  grant,
    output logic [47:0] disp_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_BLANK = 2'd3
    } state_t;

    localparam int unsigned   CW         = $clog2(SLICE);
    localparam logic [CW-1:0] HOLD_MAX   = CW'(SLICE - 1);
    localparam logic [7:0]    BLANK_LAST = 8'(BLANK_CYCLES - 1);

    // Where an owner goes when it gives the display up: through the blanking
    // gap when enabled, otherwise straight to a single IDLE cycle.
`ifdef SSEG_ARB_BLANK_EN
    localparam state_t EXIT_ST = ST_BLANK;
`else
    localparam state_t EXIT_ST = ST_IDLE;
`endif

    state_t        state_q, state_d;
    state_t        idle_pick;
    logic [CW-1:0] hold_q;
    logic [7:0]    blank_q;
    logic          last_owner_q;
    logic [47:0]   disp_q;
    logic          hold_max;
    logic          entering_own;

    assign hold_max     = (hold_q == HOLD_MAX);
    assign entering_own = ((state_d == ST_OWN0) || (state_d == ST_OWN1)) && (state_d != state_q);

    // Arbitration decision used from IDLE and at the end of BLANK; ties go to
    // whichever requester did not own the display last.
    always_comb begin
        idle_pick = ST_IDLE;
        case (req)
            2'b01:   idle_pick = ST_OWN0;
            2'b10:   idle_pick = ST_OWN1;
            2'b11:   idle_pick = last_owner_q ? ST_OWN0 : ST_OWN1;
            default: idle_pick = ST_IDLE;
        endcase
    end

    // Next-state: owners release on dropped req or on slice expiry with a waiter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = idle_pick;
            ST_OWN0: begin
                if (!req[0] || (req[1] && hold_max)) begin
                    state_d = EXIT_ST;
                end
            end
            ST_OWN1: begin
                if (!req[1] || (req[0] && hold_max)) begin
                    state_d = EXIT_ST;
                end
            end
            ST_BLANK: begin
                if (blank_q == BLANK_LAST) begin
                    state_d = idle_pick;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, hold/blank counters, last owner and the registered display bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            blank_q      <= '0;
            last_owner_q <= 1'b1;
            disp_q       <= 48'h0;
        end else begin
            state_q <= state_d;

            if (entering_own) begin
                hold_q       <= '0;
                last_owner_q <= (state_d == ST_OWN1);
            end else if (((state_q == ST_OWN0) || (state_q == ST_OWN1)) && !hold_max) begin
                hold_q <= hold_q + 1'b1;
            end

            if (state_q == ST_BLANK) begin
                blank_q <= blank_q + 8'd1;
            end else begin
                blank_q <= 8'd0;
            end

            // Only the current owner's frame is ever forwarded; all digits
            // are disabled whenever nobody owns the display.
            case (state_q)
                ST_OWN0: disp_q <= frame0;
                ST_OWN1: disp_q <= frame1;
                default: disp_q <= 48'h0;
            endcase
        end
    end

    assign grant    = {state_q == ST_OWN1, state_q == ST_OWN0};
    assign disp_out = disp_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sseg_share_arbiter.sv
`timescale 1ns/1ps
module tb_sseg_share_arbiter;

    localparam int SLICE        = 8;
    localparam int BLANK_CYCLES = 2;
`ifdef SSEG_ARB_BLANK_EN
    localparam int GAP      = BLANK_CYCLES;
    localparam bit BLANK_EN = 1'b1;
`else
    localparam int GAP      = 1;
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [47:0] frame0, frame1;
    logic [1:0]  grant;
    logic [47:0] disp_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the display, how long it has held it, how
    // many non-granted cycles remain before the next decision, last owner.
    int          m_owner;
    int          m_held;
    int          m_pend;
    int          m_last;
    logic [47:0] m_disp;

    sseg_share_arbiter #(.SLICE(SLICE), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk(clk), .reset(reset), .req(req), .frame0(frame0), .frame1(frame1),
        .grant(grant), .disp_out(disp_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_grant();
        return (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic exp_busy();
        return (m_owner >= 0) || (BLANK_EN && (m_pend > 0));
    endfunction

    // Advance model and DUT by one clock edge; leaves time at edge + 1.
    task automatic step();
        int n_owner = m_owner;
        int n_held  = m_held;
        int n_pend  = m_pend;
        int n_last  = m_last;
        int pick    = -1;
        logic [47:0] n_disp;
        n_disp = (m_owner == 0) ? frame0 : (m_owner == 1) ? frame1 : 48'h0;
        if (reset) begin
            n_owner = -1; n_held = 0; n_pend = 0; n_last = 1; n_disp = 48'h0;
        end else begin
            if (req == 2'b01) pick = 0;
            else if (req == 2'b10) pick = 1;
            else if (req == 2'b11) pick = (m_last == 1) ? 0 : 1;
            if (m_owner >= 0) begin
                n_held = m_held + 1;
                if (!req[m_owner] || (req[1 - m_owner] && n_held >= SLICE)) begin
                    n_owner = -1;
                    n_pend  = GAP;
                end
            end else if (m_pend > 1) begin
                n_pend = m_pend - 1;
            end else begin
                n_pend = 0;
                if (pick >= 0) begin
                    n_owner = pick; n_held = 0; n_last = pick;
                end
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_held = n_held; m_pend = n_pend; m_last = n_last; m_disp = n_disp;
    endtask

    task automatic rand_frames();
        frame0 = {16'($urandom), 32'($urandom)};
        frame1 = {16'($urandom), 32'($urandom)};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req = 2'b11;
        rand_frames();
        do_reset();
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b want=00", grant); end
        checks++;
        if (disp_out !== 48'h0) begin failures++; $display("FAIL reset_disp got=%h want=0", disp_out); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_single_owner();
        req = 2'b00;
        do_reset();
        req    = 2'b01;
        frame0 = 48'h0123456789AB;
        frame1 = 48'hFEDCBA987654;
        step();
        checks++;
        if (grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%b want=01", grant); end
        checks++;
        if (disp_out !== 48'h0) begin failures++; $display("FAIL single_disp0 got=%h want=0", disp_out); end
        step();
        checks++;
        if (disp_out !== 48'h0123456789AB) begin
            failures++; $display("FAIL single_disp got=%h want=0123456789ab", disp_out);
        end
    endtask

    task automatic test_slice_tie();
        logic [1:0] want;
        logic       want_busy;
        req = 2'b00;
        do_reset();
        req = 2'b11;
        for (int i = 0; i < SLICE + GAP + 3; i++) begin
            rand_frames();
            step();
            if (i < SLICE) begin want = 2'b01; want_busy = 1'b1; end
            else if (i < SLICE + GAP) begin want = 2'b00; want_busy = BLANK_EN; end
            else begin want = 2'b10; want_busy = 1'b1; end
            checks++;
            if (grant !== want) begin failures++; $display("FAIL tie_grant cyc=%0d got=%b want=%b", i, grant, want); end
            checks++;
            if (busy !== want_busy) begin failures++; $display("FAIL tie_busy cyc=%0d got=%b want=%b", i, busy, want_busy); end
            checks++;
            if (disp_out !== m_disp) begin failures++; $display("FAIL tie_disp cyc=%0d got=%h want=%h", i, disp_out, m_disp); end
        end
    endtask

    task automatic test_alone();
        req = 2'b00;
        do_reset();
        req = 2'b01;
        for (int i = 0; i < 50; i++) begin
            rand_frames();
            step();
            checks++;
            if (grant !== 2'b01 || busy !== 1'b1) begin
                failures++; $display("FAIL alone cyc=%0d grant=%b busy=%b want 01/1", i, grant, busy);
            end
            checks++;
            if (disp_out !== m_disp) begin failures++; $display("FAIL alone_disp cyc=%0d got=%h want=%h", i, disp_out, m_disp); end
        end
    endtask

    task automatic test_handover();
        logic [1:0] want;
        req = 2'b00;
        do_reset();
        req = 2'b10;
        for (int i = 0; i < 4; i++) begin rand_frames(); step(); end
        checks++;
        if (grant !== 2'b10) begin failures++; $display("FAIL hand_own1 got=%b want=10", grant); end
        req = 2'b01;
        for (int i = 0; i < GAP + 2; i++) begin
            rand_frames();
            step();
            want = (i < GAP) ? 2'b00 : 2'b01;
            checks++;
            if (grant !== want) begin failures++; $display("FAIL hand_grant cyc=%0d got=%b want=%b", i, grant, want); end
            checks++;
            if (disp_out !== m_disp) begin failures++; $display("FAIL hand_disp cyc=%0d got=%h want=%h", i, disp_out, m_disp); end
        end
    endtask

    task automatic test_reset_mid();
        req = 2'b00;
        do_reset();
        req = 2'b11;
        for (int i = 0; i < SLICE + 1; i++) begin rand_frames(); step(); end
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL mid_gap_pre got=%b want=00", grant); end
        reset = 1'b1;
        step();
        checks++;
        if (grant !== 2'b00 || disp_out !== 48'h0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_gap_reset grant=%b disp=%h busy=%b want 00/0/0", grant, disp_out, busy);
        end
        reset = 1'b0;
        req   = 2'b10;
        step();
        step();
        checks++;
        if (grant !== 2'b10) begin failures++; $display("FAIL mid_own1_pre got=%b want=10", grant); end
        reset = 1'b1;
        step();
        checks++;
        if (grant !== 2'b00 || disp_out !== 48'h0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_own1_reset grant=%b disp=%h busy=%b want 00/0/0", grant, disp_out, busy);
        end
        reset = 1'b0;
        req   = 2'b11;
        step();
        checks++;
        if (grant !== 2'b01) begin failures++; $display("FAIL mid_tie got=%b want=01", grant); end
    endtask

    task automatic test_random();
        req = 2'b00;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 5) == 0) req[1] = ~req[1];
            reset = ($urandom_range(0, 199) == 0);
            rand_frames();
            step();
            checks++;
            if (grant !== exp_grant()) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", i, grant, exp_grant()); end
            checks++;
            if (busy !== exp_busy()) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", i, busy, exp_busy()); end
            checks++;
            if (disp_out !== m_disp) begin failures++; $display("FAIL rnd_disp cyc=%0d got=%h want=%h", i, disp_out, m_disp); end
            checks++;
            if (grant === 2'b11) begin failures++; $display("FAIL rnd_onehot cyc=%0d got=%b want=not 11", i, grant); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; frame0 = 48'h0; frame1 = 48'h0;
        m_owner = -1; m_held = 0; m_pend = 0; m_last = 1; m_disp = 48'h0;
        #2;
        test_reset();
        test_single_owner();
        test_slice_tie();
        test_alone();
        test_handover();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_share_arbiter.md
SSEG_SHARE_ARBITER -- requirements
Module: sseg_share_arbiter

Interface
REQ-001 Parameter SLICE, default 100000000, max cycles an owner keeps the display while the other requester waits; legal range 2..2^27.
REQ-002 Parameter BLANK_CYCLES, default 2, length of the all-digits-off gap between owners; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  2  req[i] high = requester i wants the display; level, held while wanted.
REQ-006 frame0  input  48  requester 0 digit bus, digit k at [6k+5:6k] = {en, hex[3:0], dp}.
REQ-007 frame1  input  48  requester 1 digit bus, same packing.
REQ-008 grant  output  2  one-hot-or-zero, grant[i] high while requester i owns the display.
REQ-009 disp_out  output  48  registered digit bus to the 8-digit display driver, same packing.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 States: IDLE, OWN0, OWN1, BLANK; exactly one active per cycle.
REQ-012 IDLE: one req high -> own that requester next cycle; both high -> own the requester not equal to last_owner; neither -> stay.
REQ-013 last_owner is a 1-bit register updated on every entry to OWNi; reset value 1, so requester 0 wins the first tie.
REQ-014 OWNi: grant[i]=1; disp_out <= frame_i each cycle (1-cycle latency from frame_i to disp_out).
REQ-015 Hold counter clears on entry to OWNi and increments each cycle in OWNi, saturating at SLICE-1.
REQ-016 OWNi exits to BLANK when req[i] drops, or when req[other] is high and counter equals SLICE-1; grant drops on the same edge.
REQ-017 If req[i] drops and req[other] rises in the same cycle, single exit to BLANK; other owns after the gap.
REQ-018 BLANK: grant=0, disp_out <= 48'h0 (all digits disabled), runs BLANK_CYCLES cycles, then applies the IDLE decision rule on the cycle it expires.
REQ-019 IDLE: grant=0, disp_out <= 48'h0.
REQ-020 Owner with no competitor keeps grant indefinitely; counter saturates, no wrap.
REQ-021 grant never has both bits set; a change of owner never occurs without at least one non-granted cycle.
REQ-022 Frame inputs of the non-owner never reach disp_out.

Reset
REQ-023 reset high on a clock edge forces IDLE, grant=2'b00, disp_out=48'h0, busy=0, counters=0, last_owner=1, overriding any state including mid-BLANK or mid-OWN.
REQ-024 First grant possible on the first edge after reset deasserts.

Configuration
REQ-025 Macro SSEG_ARB_BLANK_EN: when defined, owner changes pass through BLANK as specified.
REQ-026 When SSEG_ARB_BLANK_EN is undefined, BLANK is absent: OWNi exits go directly through one IDLE cycle (grant=0, disp_out=0) and BLANK_CYCLES is ignored; all other behaviour unchanged.

Verification (SLICE=8, BLANK_CYCLES=2, SSEG_ARB_BLANK_EN defined unless noted)
REQ-027 Reset, then req=01, frame0=48'h0123456789AB -> grant=01 after 1 edge, disp_out=48'h0123456789AB 1 cycle later.
REQ-028 From IDLE, req=11 after reset -> grant=01; hold req=11 -> grant=00 after 8 owned cycles, 2 blank cycles with disp_out=0, then grant=10.
REQ-029 Owner 0 alone, req=01 for 50 cycles -> grant stays 01 throughout, no blank.
REQ-030 Owner 1, req drops 1->0 while req[0] rises same cycle -> grant 10 -> 00 for 2 cycles -> 01.
REQ-031 reset asserted mid-BLANK and mid-OWN1 -> next edge grant=00, disp_out=0, busy=0; next tie goes to requester 0.
REQ-032 SSEG_ARB_BLANK_EN undefined, req=11 -> slice expiry gives exactly one grant=00 cycle between owners.
